pn_seq_checker: RTL and testbench

Serial receive-side checker for the 3-bit PN sequence generator: samples its `s3` bit stream, self-synchronises to the sequence and then tracks it with a flywheel predictor. It reports lock status, per-bit error pulses and an optional saturating error count. It sits at the far end of the PN link, in the same clock domain as the generator, and is used for link bring-up and bit-error checks.

---
 rtl/pn_seq_checker.sv | 148 ++++++++++++++
 tb/tb_pn_seq_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_seq_checker.sv
// pn_seq_checker: receive-side checker for the 3-bit PN sequence
// b(n+3) = b(n) ^ b(n+1). It fills a 3-bit history, searches for
// LOCK_CNT consecutive correct predictions, then flywheels on its own
// predictions and reports mismatches. Lock is dropped after LOSS_CNT
// consecutive mismatches.
// Optional feature macro: PN_CHK_ERRCNT_EN builds the saturating
// err_count register; without it err_count is tied to zero.
module pn_seq_checker #(
  parameter int unsigned LOCK_CNT = 7,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,      // synchronous, active low
  input  logic             din,
  input  logic             din_valid,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

  state_t     state_q, state_d;
  logic [2:0] hist_q, hist_d;     // hist[0] is the newest bit
  logic [1:0] fill_q, fill_d;
  logic [3:0] match_q, match_d;
  logic [3:0] miss_q, miss_d;
  logic       bit_err_q, bit_err_d;
  logic       locked_q;
  logic       pred;

  assign pred = hist_q[2] ^ hist_q[1];

  // Next-state logic: only a valid bit can move the FSM or its counters.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    miss_d    = miss_q;
    bit_err_d = 1'b0;
    if (din_valid) begin
      case (state_q)
        ST_FILL: begin
          hist_d = {hist_q[1:0], din};
          if (fill_q == 2'd2) begin
            fill_d  = 2'd0;
            match_d = 4'd0;
            state_d = ST_SEARCH;
          end else begin
            fill_d = fill_q + 2'd1;
          end
        end
        ST_SEARCH: begin
          hist_d = {hist_q[1:0], din};
          // An all-zero history never counts, so a stuck-at-0 line cannot lock.
          if ((din == pred) && (hist_q != 3'b000)) begin
            match_d = match_q + 4'd1;
            if (match_d == LOCK_TGT) begin
              state_d = ST_LOCKED;
              match_d = 4'd0;
              miss_d  = 4'd0;
            end
          end else begin
            match_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: shift the prediction so a bad bit never corrupts history.
          hist_d = {hist_q[1:0], pred};
          if (din != pred) begin
            bit_err_d = 1'b1;
            miss_d    = miss_q + 4'd1;
            if (miss_d == LOSS_TGT) begin
              state_d = ST_FILL;
              hist_d  = 3'b000;
              fill_d  = 2'd0;
              match_d = 4'd0;
              miss_d  = 4'd0;
            end
          end else begin
            miss_d = 4'd0;
          end
        end
        default: begin
          state_d = ST_FILL;
          hist_d  = 3'b000;
          fill_d  = 2'd0;
          match_d = 4'd0;
          miss_d  = 4'd0;
        end
      endcase
    end
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_FILL;
      hist_q    <= 3'b000;
      fill_q    <= 2'd0;
      match_q   <= 4'd0;
      miss_q    <= 4'd0;
      bit_err_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      bit_err_q <= bit_err_d;
      locked_q  <= (state_d == ST_LOCKED);
    end
  end

  assign locked  = locked_q;
  assign bit_err = bit_err_q;

`ifdef PN_CHK_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;
  logic             err_inc;

  assign err_inc = din_valid && (state_q == ST_LOCKED) && (din != pred);

  // Saturating count of mismatches seen while locked; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_pn_seq_checker.sv
// Scoreboard bench for pn_seq_checker: the stimulus process feeds a
// reference model and queues the expected outputs; a monitor pops and
// compares them one cycle at a time.
module tb_pn_seq_checker;

  localparam int LOCK_CNT = 7;
  localparam int LOSS_CNT = 3;
  localparam int CNT_W    = 3;               // small so saturation is reachable
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef PN_CHK_ERRCNT_EN
  localparam int SAT_EXP = CNT_MAX;
`else
  localparam int SAT_EXP = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             locked;
  logic             bit_err;
  logic [CNT_W-1:0] err_count;

  pn_seq_checker #(
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .din      (din),
    .din_valid(din_valid),
    .locked   (locked),
    .bit_err  (bit_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit lk;
    bit be;
    int ec;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: mode 0 = filling, 1 = searching, 2 = locked.
  // m_win holds the last three sequence bits, oldest first.
  int m_mode = 0;
  bit m_win[$];
  int m_run  = 0;
  int m_errs = 0;
  bit m_be   = 1'b0;

  // Clean PN stream from seed 001: 0010111 repeating, first bit at pat[6].
  bit [6:0] pat = 7'b0010111;
  int pos = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit d);
    bit p;
    m_be = 1'b0;
    if (!r) begin
      m_mode = 0;
      m_win.delete();
      m_run  = 0;
      m_errs = 0;
    end else if (v) begin
      case (m_mode)
        0: begin
          m_win.push_back(d);
          if (m_win.size() == 3) begin
            m_mode = 1;
            m_run  = 0;
          end
        end
        1: begin
          // next sequence bit predicted from the law b(n+3) = b(n) ^ b(n+1)
          p = m_win[0] ^ m_win[1];
          if ((d == p) && (m_win[0] || m_win[1] || m_win[2])) m_run++;
          else m_run = 0;
          void'(m_win.pop_front());
          m_win.push_back(d);
          if (m_run == LOCK_CNT) begin
            m_mode = 2;
            m_run  = 0;
          end
        end
        default: begin
          p = m_win[0] ^ m_win[1];
          if (d != p) begin
            m_be = 1'b1;
            if (m_errs < CNT_MAX) m_errs++;
            m_run++;
          end else begin
            m_run = 0;
          end
          void'(m_win.pop_front());
          m_win.push_back(p);
          if (m_run == LOSS_CNT) begin
            m_mode = 0;
            m_win.delete();
            m_run = 0;
          end
        end
      endcase
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit d);
    exp_t e;
    @(negedge clk);
    rst_n     = r;
    din_valid = v;
    din       = d;
    model_step(r, v, d);
    e.lk = (m_mode == 2);
    e.be = m_be;
`ifdef PN_CHK_ERRCNT_EN
    e.ec = m_errs;
`else
    e.ec = 0;
`endif
    exp_q.push_back(e);
  endtask

  // One cycle of the PN stream; invalid cycles carry junk data and do not
  // advance the stream.
  task automatic send(input bit v, input bit flip);
    bit d;
    if (v) begin
      d   = pat[6 - pos] ^ flip;
      pos = (pos == 6) ? 0 : pos + 1;
    end else begin
      d = 1'($urandom);
    end
    drive(1'b1, v, d);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'($urandom), 1'($urandom));
    drive(1'b0, 1'b1, 1'($urandom));
    pos = 0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every clock edge produces one output word to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("locked", int'(locked), int'(e.lk));
        chk("bit_err", int'(bit_err), int'(e.be));
        chk("err_count", int'(err_count), e.ec);
      end
    end
  end

  initial begin
    bit r, v, f;
    do_reset();
    after_edge();
    chk("reset_locked", int'(locked), 0);
    chk("reset_err_count", int'(err_count), 0);

    $display("scenario clean stream: lock after 10 valid bits");
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0);
    after_edge();
    chk("no_lock_after_9", int'(locked), 0);
    send(1'b1, 1'b0);
    after_edge();
    chk("lock_after_10", int'(locked), 1);
    for (int i = 0; i < 20; i++) send(1'b1, 1'b0);

    $display("scenario single inverted bit while locked");
    send(1'b1, 1'b1);
    after_edge();
    chk("single_err_pulse", int'(bit_err), 1);
    chk("single_err_keeps_lock", int'(locked), 1);
    for (int i = 0; i < 14; i++) send(1'b1, 1'b0);

    $display("scenario three inverted bits drop lock, then relock");
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1);
    after_edge();
    chk("loss_locked", int'(locked), 0);
    chk("loss_last_pulse", int'(bit_err), 1);
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0);
    after_edge();
    chk("relock_not_yet", int'(locked), 0);
    send(1'b1, 1'b0);
    after_edge();
    chk("relock_after_10", int'(locked), 1);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);

    $display("scenario stuck-at-0 line for 50 cycles");
    do_reset();
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, 1'b0);
    after_edge();
    chk("stuck0_no_lock", int'(locked), 0);

    $display("scenario alternating din_valid");
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send((i % 2) == 0, 1'b0);
      if (i == 17) begin
        after_edge();
        chk("gap_no_lock_9", int'(locked), 0);
      end
      if (i == 19) begin
        after_edge();
        chk("gap_lock_10", int'(locked), 1);
      end
    end
    for (int i = 0; i < 10; i++) send((i % 2) == 0, 1'b0);

    $display("scenario five errors then reset while locked");
    do_reset();
    for (int i = 0; i < 10; i++) send(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b1);
    pos = 0;
    after_edge();
    chk("midreset_locked", int'(locked), 0);
    chk("midreset_bit_err", int'(bit_err), 0);
    chk("midreset_err_count", int'(err_count), 0);

    $display("scenario error counter saturation");
    for (int i = 0; i < 10; i++) send(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      send(1'b1, 1'b1);
      for (int i = 0; i < 2; i++) send(1'b1, 1'b0);
    end
    after_edge();
    chk("err_count_saturated", int'(err_count), SAT_EXP);

    $display("scenario randomized stream with errors, gaps and resets");
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) != 0);
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 24) == 0);
      if (!r) drive(1'b0, v, 1'($urandom));
      else if ($urandom_range(0, 299) == 0) begin
        for (int j = 0; j < 4; j++) send(1'b1, 1'b1);
      end else send(v, f);
    end

    after_edge();
    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
